// File: rtl/usr_shift_ctrl.sv
// ---------------------------------------------------------------------------
// usr_shift_ctrl
// Command sequencer for the 8-bit universal shift register. Accepts load,
// shift-right-N, shift-left-N and snapshot commands on a valid/ready port,
// drives the register's mode/serial/parallel pins cycle by cycle, streams the
// bits leaving the register on sout, and returns the final register word on
// a response handshake.
//
// Ports
//   clk, clr                   clock, synchronous active-high reset
//   cmd_valid/cmd_ready        command handshake (ready only in IDLE)
//   cmd_op/cmd_data/cmd_count  00 load, 01 shift right, 10 shift left,
//                              11 snapshot; load word; shift count
//   sin                        serial bit shifted in on each shift cycle
//   sout/sout_valid            bit leaving the register this cycle
//   rsp_valid/rsp_ready        response handshake, rsp_data = register word
//   busy                       controller not in IDLE
//   usr_clr_n, usr_s1, usr_s0, usr_pn, usr_dsr, usr_dsl, usr_p
//                              shift register control/data pins
//   usr_q                      shift register output word
// ---------------------------------------------------------------------------
module usr_shift_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             sin,
  output logic             sout,
  output logic             sout_valid,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic             usr_clr_n,
  output logic             usr_s1,
  output logic             usr_s0,
  output logic             usr_pn,
  output logic             usr_dsr,
  output logic             usr_dsl,
  output logic [WIDTH-1:0] usr_p,
  input  logic [WIDTH-1:0] usr_q
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_SNAP  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_left_q, dir_left_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] cnt_clamp_s;

  // Registered output controls, decoded from the next state so they line up
  // with the state they belong to.
  logic ready_q, ready_d;
  logic busy_q, busy_d;
  logic rsp_valid_q, rsp_valid_d;
  logic s1_q, s1_d;
  logic s0_q, s0_d;
  logic pn_q, pn_d;
  logic shr_q, shr_d;
  logic shl_q, shl_d;
  logic load_q, load_d;

  // Clamp the requested shift count to the register width.
  always_comb begin
    if (cmd_count > CNT_W'(WIDTH)) begin
      cnt_clamp_s = CNT_W'(WIDTH);
    end else begin
      cnt_clamp_s = cmd_count;
    end
  end

  // Next-state logic and output decode for the following cycle.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_left_d = dir_left_q;
    data_d     = data_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          data_d     = cmd_data;
          dir_left_d = (cmd_op == 2'b10);
          cnt_d      = cnt_clamp_s;
          case (cmd_op)
            2'b00:   state_d = ST_LOAD;
            2'b11:   state_d = ST_SNAP;
            default: state_d = (cnt_clamp_s == {CNT_W{1'b0}}) ? ST_DONE : ST_SHIFT;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: state_d = ST_DONE;
      ST_SNAP: state_d = ST_DONE;
      ST_SHIFT: begin
        cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        // <=1 rather than ==1 so a corrupted zero count cannot spin forever
        if (cnt_q <= {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d     = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_DONE);
    pn_d        = (state_d == ST_SNAP);
    load_d      = (state_d == ST_LOAD);
    shr_d       = (state_d == ST_SHIFT) && !dir_left_d;
    shl_d       = (state_d == ST_SHIFT) && dir_left_d;
    case (state_d)
      ST_LOAD:  begin s1_d = 1'b0; s0_d = 1'b0; end
      ST_SHIFT: begin s1_d = dir_left_d; s0_d = !dir_left_d; end
      default:  begin s1_d = 1'b1; s0_d = 1'b1; end
    endcase
  end

  // State, captured command and registered control outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      dir_left_q  <= 1'b0;
      data_q      <= {WIDTH{1'b0}};
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      s1_q        <= 1'b1;
      s0_q        <= 1'b1;
      pn_q        <= 1'b0;
      shr_q       <= 1'b0;
      shl_q       <= 1'b0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dir_left_q  <= dir_left_d;
      data_q      <= data_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      s1_q        <= s1_d;
      s0_q        <= s0_d;
      pn_q        <= pn_d;
      shr_q       <= shr_d;
      shl_q       <= shl_d;
      load_q      <= load_d;
    end
  end

  assign cmd_ready  = ready_q;
  assign busy       = busy_q;
  assign rsp_valid  = rsp_valid_q;
  assign usr_s1     = s1_q;
  assign usr_s0     = s0_q;
  assign usr_pn     = pn_q;

  // The register clears on the same edge the controller resets.
  assign usr_clr_n  = ~clr;

  // The register shifts from P, so P must follow q except while loading.
  assign usr_p      = load_q ? data_q : usr_q;
  assign rsp_data   = usr_q;

  assign usr_dsr    = shr_q & sin;
  assign usr_dsl    = shl_q & sin;
  assign sout_valid = shr_q | shl_q;
  assign sout       = (shr_q & usr_q[0]) | (shl_q & usr_q[WIDTH-1]);

endmodule

// File: tb/tb_usr_shift_ctrl.sv
module tb_usr_shift_ctrl;

  logic       clk;
  logic       clr;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic [3:0] cmd_count;
  logic       sin;
  logic       sout;
  logic       sout_valid;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic       usr_clr_n;
  logic       usr_s1;
  logic       usr_s0;
  logic       usr_pn;
  logic       usr_dsr;
  logic       usr_dsl;
  logic [7:0] usr_p;
  logic [7:0] usr_q;

  // Shift register the controller drives
  logic [7:0] reg_q;
  logic [7:0] reg_pl;

  // Reference: register word and parallel latch expected from command history
  logic [7:0] m_reg;
  logic [7:0] m_pl;

  int n_checks = 0;
  int n_fail   = 0;

  usr_shift_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .clr(clr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .sin(sin),
    .sout(sout), .sout_valid(sout_valid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .usr_clr_n(usr_clr_n), .usr_s1(usr_s1), .usr_s0(usr_s0),
    .usr_pn(usr_pn), .usr_dsr(usr_dsr), .usr_dsl(usr_dsl),
    .usr_p(usr_p), .usr_q(usr_q)
  );

  assign usr_q = reg_q;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Universal shift register behaviour
  always_ff @(posedge clk) begin
    if (!usr_clr_n) begin
      reg_q  <= 8'h00;
      reg_pl <= 8'h00;
    end else begin
      case ({usr_s1, usr_s0})
        2'b00:   reg_q <= usr_p;
        2'b01:   reg_q <= {usr_dsr, usr_p[7:1]};
        2'b10:   reg_q <= {usr_p[6:0], usr_dsl};
        default: if (usr_pn) reg_pl <= usr_p;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Issue one command from IDLE and follow it to the end of its response.
  // Entered and left at #1 after a rising edge.
  task automatic run_cmd(input logic [1:0] op, input logic [7:0] data,
                         input logic [3:0] count, input int sin_mode, input int hold);
    int n;
    logic b;
    n = (count > 4'd8) ? 8 : int'(count);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    cmd_count = count;
    sin       = 1'($urandom);
    @(negedge clk);
    chk("idle_ready", cmd_ready, 1);
    chk("idle_busy", busy, 0);
    chk("idle_rsp", rsp_valid, 0);
    chk("idle_mode", {usr_s1, usr_s0, usr_pn}, 3'b110);
    chk("idle_serial", {sout_valid, sout, usr_dsr, usr_dsl}, 4'b0000);
    chk("idle_p", usr_p, m_reg);
    @(posedge clk); #1;
    // Fields must be ignored after acceptance
    cmd_valid = 1'b0;
    cmd_op    = 2'($urandom);
    cmd_data  = 8'($urandom);
    cmd_count = 4'($urandom);
    case (op)
      2'b00: begin
        @(negedge clk);
        chk("load_mode", {usr_s1, usr_s0, usr_pn}, 3'b000);
        chk("load_p", usr_p, data);
        chk("load_busy", {busy, cmd_ready, rsp_valid}, 3'b100);
        @(posedge clk); #1;
        m_reg = data;
      end
      2'b11: begin
        @(negedge clk);
        chk("snap_mode", {usr_s1, usr_s0, usr_pn}, 3'b111);
        chk("snap_p", usr_p, m_reg);
        chk("snap_busy", {busy, cmd_ready, rsp_valid}, 3'b100);
        @(posedge clk); #1;
        m_pl = m_reg;
      end
      default: begin
        for (int k = 0; k < n; k++) begin
          case (sin_mode)
            0:       sin = 1'b0;
            1:       sin = 1'b1;
            default: sin = 1'($urandom);
          endcase
          b = (op == 2'b01) ? m_reg[0] : m_reg[7];
          @(negedge clk);
          chk("shift_sout", {sout_valid, sout}, {1'b1, b});
          chk("shift_mode", {usr_s1, usr_s0, usr_pn}, (op == 2'b01) ? 3'b010 : 3'b100);
          chk("shift_din", {usr_dsr, usr_dsl}, (op == 2'b01) ? {sin, 1'b0} : {1'b0, sin});
          chk("shift_busy", {busy, cmd_ready, rsp_valid}, 3'b100);
          @(posedge clk); #1;
          if (op == 2'b01) m_reg = {sin, m_reg[7:1]};
          else             m_reg = {m_reg[6:0], sin};
        end
      end
    endcase
    for (int h = 0; h <= hold; h++) begin
      rsp_ready = (h == hold);
      // A command offered while busy must not be taken
      cmd_valid = (h != hold);
      cmd_op    = 2'b00;
      cmd_data  = 8'($urandom);
      sin       = 1'($urandom);
      @(negedge clk);
      chk("done_rsp", {rsp_valid, cmd_ready, busy}, 3'b101);
      chk("done_data", rsp_data, m_reg);
      chk("done_mode", {usr_s1, usr_s0, usr_pn}, 3'b110);
      chk("done_serial", {sout_valid, sout, usr_dsr, usr_dsl}, 4'b0000);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    chk("reg_word", reg_q, m_reg);
    chk("reg_latch", reg_pl, m_pl);
  endtask

  initial begin
    clr       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = 8'h00;
    cmd_count = 4'h0;
    sin       = 1'b0;
    rsp_ready = 1'b0;
    m_reg     = 8'h00;
    m_pl      = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {cmd_ready, rsp_valid, busy}, 3'b100);
    chk("rst_mode", {usr_s1, usr_s0, usr_pn, usr_clr_n}, 4'b1100);
    chk("rst_serial", {sout, sout_valid, usr_dsr, usr_dsl}, 4'b0000);
    chk("rst_data", rsp_data, 8'h00);
    @(posedge clk); #1;
    clr = 1'b0;

    run_cmd(2'b00, 8'hA5, 4'd0, 0, 0);
    run_cmd(2'b01, 8'h00, 4'd3, 1, 0);
    chk("tp_shr3", reg_q, 8'hF4);
    run_cmd(2'b10, 8'h00, 4'd2, 0, 0);
    chk("tp_shl2", reg_q, 8'hD0);
    run_cmd(2'b10, 8'h00, 4'd12, 0, 0);
    chk("tp_clamp", reg_q, 8'h00);
    run_cmd(2'b00, 8'h3C, 4'd0, 0, 0);
    run_cmd(2'b11, 8'h00, 4'd0, 0, 0);
    chk("tp_snap", reg_pl, 8'h3C);
    run_cmd(2'b01, 8'h00, 4'd0, 2, 0);
    chk("tp_cnt0", reg_q, 8'h3C);
    run_cmd(2'b00, 8'h55, 4'd0, 0, 5);

    // Reset in the second cycle of a shift-right-6
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_count = 4'd6;
    sin       = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("abort_c1", sout_valid, 1);
    @(posedge clk); #1;
    clr = 1'b1;
    @(negedge clk);
    chk("abort_c2", sout_valid, 1);
    chk("abort_clrn", usr_clr_n, 0);
    @(posedge clk); #1;
    clr   = 1'b0;
    m_reg = 8'h00;
    m_pl  = 8'h00;
    @(negedge clk);
    chk("abort_idle", {cmd_ready, busy, rsp_valid, sout_valid}, 4'b1000);
    chk("abort_reg", reg_q, 8'h00);
    @(posedge clk); #1;
    run_cmd(2'b00, 8'h81, 4'd0, 0, 0);
    chk("abort_after", reg_q, 8'h81);

    for (int i = 0; i < 150; i++) begin
      run_cmd(2'($urandom), 8'($urandom), 4'($urandom_range(0, 15)), 2,
              int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/usr_shift_ctrl.md
Name: usr_shift_ctrl

Overview:
- Command sequencer for the team's 8-bit universal shift register (mode select s1/s0, serial inputs dsr/dsl, parallel-strobe pn, active-low clr).
- Accepts load, shift-right-N, shift-left-N and snapshot commands over a valid/ready interface.
- Drives the register's control pins cycle by cycle, streams the shifted-out bits serially, and returns the final register word on a response handshake.
- Sits between a host/bus-side requester and one shift register instance.

Parameters:
- WIDTH, 8, register width; fixed to match the shift register.
- CNT_W, 4, width of cmd_count; counts above WIDTH clamp to WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- clr  in  1  synchronous active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command (high only in IDLE).
- cmd_op  in  2  00 load, 01 shift right, 10 shift left, 11 snapshot.
- cmd_data  in  WIDTH  load word; ignored for other ops.
- cmd_count  in  CNT_W  number of shifts.
- sin  in  1  serial bit shifted in during each SHIFT cycle.
- sout  out  1  bit leaving the register this cycle.
- sout_valid  out  1  sout is meaningful.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  WIDTH  register contents at completion.
- busy  out  1  high whenever state is not IDLE.
- usr_clr_n  out  1  to register clr; equals ~clr, combinational.
- usr_s1, usr_s0  out  1 each  register mode.
- usr_pn  out  1  register parallel-out strobe.
- usr_dsr, usr_dsl  out  1 each  register serial inputs.
- usr_p  out  WIDTH  register parallel input.
- usr_q  in  WIDTH  register q output.

Behaviour:
- Register semantics relied on: 00 q<=P; 01 q<={dsr,P[7:1]}; 10 q<={P[6:0],dsl}; 11 with pn=1 latches P into p1..p8; 11 with pn=0 holds q (HOLD).
- States: IDLE, LOAD, SHIFT, SNAP, DONE.
- IDLE: cmd_ready=1; drives HOLD (s=11, pn=0). On cmd_valid, capture op, data and cnt=min(cmd_count,WIDTH), then go to:
  - LOAD if op=00;
  - SHIFT if op=01/10 and cnt>0;
  - DONE if op=01/10 and cnt=0;
  - SNAP if op=11.
- LOAD (1 cycle): s=00, usr_p=captured data, then DONE.
- SHIFT:
  - usr_p=usr_q (feedback).
  - Right shift: s=01, usr_dsr=sin, sout=usr_q[0].
  - Left shift: s=10, usr_dsl=sin, sout=usr_q[WIDTH-1].
  - sout_valid=1; cnt decrements each cycle; leave to DONE in the cycle cnt=1.
  - Exactly cnt SHIFT cycles.
- SNAP (1 cycle): s=11, pn=1, usr_p=usr_q, then DONE.
- DONE: rsp_valid=1, rsp_data=usr_q (live, stable because register is in HOLD). Stay until rsp_ready=1, then IDLE. No new command is accepted in the same cycle as the response.
- Latency from accept edge T:
  - load and snapshot: response at T+2;
  - shift N: response at T+N+1;
  - count 0: response at T+1.
- Outside SHIFT: sout=0, sout_valid=0, usr_dsr=usr_dsl=0. In IDLE/DONE, usr_p=usr_q.
- Reset (clr=1 at an edge): state←IDLE, cnt←0. Takes effect from any state, including mid-SHIFT and DONE.
  - The aborted command produces no response.
  - usr_clr_n=0 during clr, so the register clears on the same edge.
- Reset output values: cmd_ready=1, rsp_valid=0, busy=0, sout=0, sout_valid=0, usr_s1=usr_s0=1, usr_pn=0, usr_dsr=usr_dsl=0, rsp_data=usr_q (0 after clear).
- cmd_valid while busy is ignored (no capture); the requester holds it until cmd_ready.
- cmd_op/cmd_data/cmd_count are sampled only at acceptance; later changes have no effect.

Test Plan:
- Reset, then load cmd_data=0xA5 -> usr_s=00 with usr_p=0xA5 at T+1; rsp_valid at T+2 with rsp_data=0xA5.
- From 0xA5, shift right count=3, sin=1 -> q=0xD2, 0xE9, 0xF4; sout=1,0,1 with sout_valid on 3 cycles; rsp_data=0xF4 at T+4.
- From 0xF4, shift left count=2, sin=0 -> q=0xE8, 0xD0; sout=1,1; rsp_data=0xD0. Then count=12 -> exactly 8 shift cycles, rsp_data=0x00.
- Snapshot of 0x3C -> usr_pn=1 for exactly one cycle with usr_p=0x3C; register p1..p8=0,0,1,1,1,1,0,0; rsp_data=0x3C. Shift with count=0 -> rsp_valid at T+1, register unchanged.
- Hold rsp_ready=0 for 5 cycles in DONE -> rsp_valid and rsp_data stable, cmd_ready=0, a concurrent cmd_valid is not captured. Release -> IDLE next cycle.
- Assert clr during the 2nd cycle of a shift-right-6 -> next cycle IDLE, register=0x00, no rsp_valid. The following load 0x81 completes normally.
